// File: rtl/iic_slave.sv
// I2C target exposing a 256x8 memory image through a synchronous memory port.
// Optional sequential addressing: define IIC_SLAVE_AUTOINC_EN.
module iic_slave #(
   parameter int FILT_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [6:0] dev_id,
   input  logic       wp,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   input  logic [7:0] mem_rdata,
   output logic       busy,
   output logic       wr_done
);

`ifdef IIC_SLAVE_AUTOINC_EN
   localparam logic AUTOINC = 1'b1;
`else
   localparam logic AUTOINC = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_DEVADDR, S_WADDR, S_WDATA, S_RDATA, S_IGNORE
   } state_t;

   // Index 0 carries scl, index 1 carries sda.
   logic [1:0] sync1_q, sync2_q, filt_q, filt_dq;
   logic [3:0] cnt_q [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         filt_q  <= '1;
         filt_dq <= '1;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= {sda, scl};
         sync2_q <= sync1_q;
         filt_dq <= filt_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == 4'(FILT_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 4'd1;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
   assign scl_f    = filt_q[0];
   assign sda_f    = filt_q[1];
   assign scl_rise = scl_f & ~filt_dq[0];
   assign scl_fall = ~scl_f & filt_dq[0];
   assign start_c  = scl_f & filt_dq[0] & filt_dq[1] & ~sda_f;
   assign stop_c   = scl_f & filt_dq[0] & ~filt_dq[1] & sda_f;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic       ack_q, ack_d, rw_q, rw_d, wr_blk_q, wr_blk_d, sda_oe_q, sda_oe_d;
   logic       mem_we_q, mem_we_d, busy_q, busy_d, wr_done_q, wr_done_d;
   logic [7:0] byte_in;

   assign byte_in = {shift_q[6:0], sda_f};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ack_d       = ack_q;
      rw_d        = rw_q;
      wr_blk_d    = wr_blk_q;
      sda_oe_d    = sda_oe_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      busy_d      = busy_q;
      wr_done_d   = mem_we_q;
      // Advance only after the strobe so the memory sees the written address.
      if (AUTOINC && mem_we_q) mem_addr_d = mem_addr_q + 8'd1;

      if (stop_c) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_c) begin
         state_d   = S_DEVADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         ack_d     = 1'b0;
         wr_blk_d  = 1'b0;
      end else if (state_q inside {S_IDLE, S_IGNORE}) begin
         state_d = state_q;
      end else if (scl_rise) begin
         if (bit_cnt_q != 4'd9) bit_cnt_d = bit_cnt_q + 4'd1;
         if (bit_cnt_q < 4'd8 && state_q != S_RDATA) shift_d = byte_in;
         if (bit_cnt_q == 4'd7) begin
            case (state_q)
               S_DEVADDR: begin
                  if (byte_in[7:1] == dev_id) begin
                     ack_d  = 1'b1;
                     busy_d = 1'b1;
                     rw_d   = byte_in[0];
                  end else begin
                     state_d = S_IGNORE;
                     busy_d  = 1'b0;
                  end
               end
               S_WADDR: begin
                  mem_addr_d = byte_in;
                  ack_d      = 1'b1;
               end
               S_WDATA: begin
                  if (!wp && !wr_blk_q) begin
                     mem_wdata_d = byte_in;
                     mem_we_d    = 1'b1;
                     ack_d       = 1'b1;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
               default: ;
            endcase
         end
         if (bit_cnt_q == 4'd8 && state_q == S_RDATA) begin
            if (sda_f) state_d = S_IGNORE;
            else if (AUTOINC) mem_addr_d = mem_addr_q + 8'd1;
         end
      end else if (scl_fall) begin
         if (state_q == S_RDATA && bit_cnt_q inside {[4'd1:4'd7]}) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
         end else if (bit_cnt_q == 4'd8) begin
            sda_oe_d = (state_q != S_RDATA) && ack_q;
         end else if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            ack_d     = 1'b0;
            sda_oe_d  = 1'b0;
            if (state_q == S_WDATA) wr_blk_d = ~AUTOINC;
            if (state_q == S_WADDR) state_d = S_WDATA;
            if ((state_q == S_DEVADDR && rw_q) || state_q == S_RDATA) begin
               state_d  = S_RDATA;
               shift_d  = mem_rdata;
               sda_oe_d = ~mem_rdata[7];
            end else if (state_q == S_DEVADDR) begin
               state_d = S_WADDR;
            end
         end
      end
   end

   // NOTE: async reset clears the pad enable at once, so sda is freed mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ack_q       <= 1'b0;
         rw_q        <= 1'b0;
         wr_blk_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ack_q       <= ack_d;
         rw_q        <= rw_d;
         wr_blk_q    <= wr_blk_d;
         sda_oe_q    <= sda_oe_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         busy_q      <= busy_d;
         wr_done_q   <= wr_done_d;
      end
   end

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign busy      = busy_q;
   assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_iic_slave.sv
// Bit-banged I2C master against iic_slave with a scoreboard on bus bits and memory writes.
module tb_iic_slave;
   localparam int Q = 12;

   logic       clk = 1'b0;
   logic       rst, scl, m_low, wp;
   logic [6:0] dev_id;
   wire        sda;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, busy, wr_done;

   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_wa, tb_wd;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic [7:0] val;
   } bus_item_t;

   bus_item_t   exp_bus_q[$];
   bus_item_t   act_bus_q[$];
   logic [15:0] exp_wr_q[$];
   bus_item_t   mon_a, mon_e;
   logic [15:0] mon_w;
   logic        we_prev = 1'b0;

   always #5 clk = ~clk;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   iic_slave #(.FILT_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .dev_id    (dev_id),
      .wp        (wp),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .wr_done   (wr_done)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (tb_we) mem[tb_wa] <= tb_wd;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (act_bus_q.size() > 0) begin
         mon_a = act_bus_q.pop_front();
         if (exp_bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got %h with no expected entry", mon_a.name, mon_a.val);
         end else begin
            mon_e = exp_bus_q.pop_front();
            check(mon_e.name, {8'h00, mon_a.val}, {8'h00, mon_e.val});
         end
      end
      if (mem_we) begin
         if (exp_wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected mem_we: got addr/data %h%h", mem_addr, mem_wdata);
         end else begin
            mon_w = exp_wr_q.pop_front();
            check("mem_we addr/data", {mem_addr, mem_wdata}, mon_w);
         end
      end
      if (we_prev || wr_done) check("wr_done follows mem_we", 16'(wr_done), 16'(we_prev));
      we_prev = mem_we;
   end

   task automatic wait_q();
      repeat (Q) @(posedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      wait_q();
      m_low = ~b;
      wait_q();
      scl = 1'b1;
      wait_q();
      @(negedge clk);
      s = sda;
      wait_q();
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      m_low = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      m_low = 1'b1;
      wait_q();
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_q();
      m_low = 1'b1;
      wait_q();
      scl = 1'b1;
      wait_q();
      m_low = 1'b0;
      wait_q();
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic s;
      exp_bus_q.push_back('{nm, exp_ack ? 8'h00 : 8'h01});
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      act_bus_q.push_back('{nm, {7'h00, s}});
   endtask

   task automatic rd_byte(input logic [7:0] exp, input logic m_ack, input string nm);
      logic [7:0] v;
      logic       s;
      exp_bus_q.push_back('{nm, exp});
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         v[i] = s;
      end
      act_bus_q.push_back('{nm, v});
      if (m_ack) begin
         clk_bit(1'b0, s);
      end else begin
         exp_bus_q.push_back('{{nm, " released at nack"}, 8'h01});
         clk_bit(1'b1, s);
         act_bus_q.push_back('{{nm, " released at nack"}, {7'h00, s}});
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk);
      tb_we = 1'b1;
      tb_wa = a;
      tb_wd = d;
      @(posedge clk);
      tb_we = 1'b0;
   endtask

   task automatic idle_check_busy(input string nm);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check(nm, 16'(busy), 16'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic s;
      rst = 1'b1; scl = 1'b1; m_low = 1'b0; wp = 1'b0; dev_id = 7'h50;
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset mem_addr", 16'(mem_addr), 16'h0000);
      check("reset mem_wdata", 16'(mem_wdata), 16'h0000);
      check("reset mem_we", 16'(mem_we), 16'h0000);
      check("reset busy", 16'(busy), 16'h0000);
      check("reset wr_done", 16'(wr_done), 16'h0000);
      check("reset sda released", 16'(sda), 16'h0001);
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // Single-byte write.
      exp_wr_q.push_back({8'h12, 8'hA5});
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t1 devaddr ack");
      wr_byte(8'h12, 1'b1, "t1 waddr ack");
      wr_byte(8'hA5, 1'b1, "t1 data ack");
      @(negedge clk);
      check("t1 busy before stop", 16'(busy), 16'd1);
      i2c_stop();
      idle_check_busy("t1 busy after stop");

      // Random read with repeated START.
      poke(8'h12, 8'h3C);
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t2 devaddr ack");
      wr_byte(8'h12, 1'b1, "t2 waddr ack");
      i2c_start();
      wr_byte(8'hA1, 1'b1, "t2 read devaddr ack");
      rd_byte(8'h3C, 1'b0, "t2 rdata");
      i2c_stop();
      idle_check_busy("t2 busy after stop");

      // Address mismatch.
      i2c_start();
      wr_byte(8'hA2, 1'b0, "t3 mismatch nack");
      @(negedge clk);
      check("t3 busy stays low", 16'(busy), 16'd0);
      wr_byte(8'h12, 1'b0, "t3 ignored byte");
      i2c_stop();

      // Write protect.
      wp = 1'b1;
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t4 devaddr ack");
      wr_byte(8'h05, 1'b1, "t4 waddr ack");
      wr_byte(8'h77, 1'b0, "t4 wp data nack");
      i2c_stop();
      wp = 1'b0;
      idle_check_busy("t4 busy after stop");

      // Multi-byte write across the 0xFF wrap.
      poke(8'h01, 8'h5A);
      poke(8'h02, 8'hC3);
`ifdef IIC_SLAVE_AUTOINC_EN
      exp_wr_q.push_back({8'hFE, 8'h11});
      exp_wr_q.push_back({8'hFF, 8'h22});
      exp_wr_q.push_back({8'h00, 8'h33});
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t5 devaddr ack");
      wr_byte(8'hFE, 1'b1, "t5 waddr ack");
      wr_byte(8'h11, 1'b1, "t5 data0 ack");
      wr_byte(8'h22, 1'b1, "t5 data1 ack");
      wr_byte(8'h33, 1'b1, "t5 data2 ack");
      i2c_stop();
      i2c_start();
      wr_byte(8'hA1, 1'b1, "t5 cur read devaddr ack");
      rd_byte(8'h5A, 1'b1, "t5 cur read byte0");
      rd_byte(8'hC3, 1'b0, "t5 cur read byte1");
      i2c_stop();
`else
      exp_wr_q.push_back({8'hFE, 8'h11});
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t5 devaddr ack");
      wr_byte(8'hFE, 1'b1, "t5 waddr ack");
      wr_byte(8'h11, 1'b1, "t5 data0 ack");
      wr_byte(8'h22, 1'b0, "t5 data1 nack");
      wr_byte(8'h33, 1'b0, "t5 data2 nack");
      i2c_stop();
      i2c_start();
      wr_byte(8'hA1, 1'b1, "t5 cur read devaddr ack");
      rd_byte(8'h11, 1'b1, "t5 cur read byte0");
      rd_byte(8'h11, 1'b0, "t5 cur read byte1");
      i2c_stop();
`endif
      idle_check_busy("t5 busy after stop");

      // STOP after four data bits: partial byte is dropped.
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t6 devaddr ack");
      wr_byte(8'h12, 1'b1, "t6 waddr ack");
      clk_bit(1'b1, s);
      clk_bit(1'b0, s);
      clk_bit(1'b1, s);
      clk_bit(1'b0, s);
      i2c_stop();
      idle_check_busy("t6 busy after partial stop");

      // Reset while the target drives a read bit.
      i2c_start();
      wr_byte(8'hA1, 1'b1, "t6 read devaddr ack");
      wait_q();
      wait_q();
      scl = 1'b1;
      wait_q();
      @(negedge clk);
      check("t6 sda driven bit7", 16'(sda), 16'd0);
      rst = 1'b1;
      #1;
      check("t6 sda released on rst", 16'(sda), 16'd1);
      check("t6 mem_addr cleared on rst", 16'(mem_addr), 16'd0);
      repeat (5) @(posedge clk);
      rst = 1'b0;
      idle_check_busy("t6 busy after rst");

      // Normal transaction after the abort.
      exp_wr_q.push_back({8'h40, 8'h9C});
      i2c_start();
      wr_byte(8'hA0, 1'b1, "t7 devaddr ack");
      wr_byte(8'h40, 1'b1, "t7 waddr ack");
      wr_byte(8'h9C, 1'b1, "t7 data ack");
      i2c_stop();
      idle_check_busy("t7 busy after stop");

      repeat (20) @(posedge clk);
      @(negedge clk);
      check("pending expected writes", 16'(exp_wr_q.size()), 16'd0);
      check("pending bus items", 16'(exp_bus_q.size() + act_bus_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
